// File: rtl/ysyx_040066_mul_final_add_pkg.sv
// Shared definitions for the multiplier final carry-propagate stage.
//   XLEN     operand width; product is 2*XLEN bits
//   COLS     Wallace column count (only [2*XLEN-1:0] carry product weight)
//   TAG_W    sideband tag width (rd index)
//   SEL_*    result half select codes; codes 2/3 are reserved and act as HIGH
package ysyx_040066_mul_final_add_pkg;

  localparam int XLEN  = 64;
  localparam int COLS  = 2 * XLEN + 4;
  localparam int TAG_W = 5;

  localparam logic [1:0] SEL_LOW  = 2'd0;
  localparam logic [1:0] SEL_HIGH = 2'd1;

  // Stage 1 holding register: low half already resolved, high half still
  // in sum/carry form plus the carry out of the low half.
  typedef struct packed {
    logic [XLEN-1:0]  lo;
    logic             k;
    logic [XLEN-1:0]  s_hi;
    logic [XLEN-1:0]  c_hi;
    logic [1:0]       sel;
    logic             word;
    logic [TAG_W-1:0] tag;
  } stage1_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_040066_add64c.sv
// XLEN-bit adder with carry in and carry out.
//   a, b   addends
//   cin    carry in (weight 1)
//   sum    a + b + cin, low XLEN bits
//   cout   carry out of the top bit
module ysyx_040066_add64c
  import ysyx_040066_mul_final_add_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};

endmodule

// File: rtl/ysyx_040066_mul_final_add.sv
// Final carry-propagate stage of the Booth/Wallace multiplier. Adds the
// per-column sum/carry vectors in two 64-bit halves over two pipeline stages
// and selects the low, high or sign-extended word result.
//   clk, rst                    clock, async active-high reset
//   flush                       drop everything in flight, block input
//   in_valid/in_ready           column vectors handshake
//   in_s, in_c                  column sums / carries (carry bit i weighs 2^(i+1))
//   in_sel, in_word, in_tag     result select, *W op, sideband tag
//   out_valid/out_ready         result handshake
//   out_result, out_tag         selected result and its tag
module ysyx_040066_mul_final_add
  import ysyx_040066_mul_final_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COLS-1:0]  in_s,
  input  logic [COLS-1:0]  in_c,
  input  logic [1:0]       in_sel,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic            v1_q;
  logic            v2_q;
  stage1_t         s1_q;
  stage1_t         s1_d;
  logic            adv2;
  logic            in_fire;
  logic            move;
  logic [XLEN-1:0] lo_sum;
  logic            lo_cout;
  logic [XLEN-1:0] hi_sum;
  logic            hi_cout_unused;
  logic [XLEN-1:0] result_d;
  logic            unused_cols;

  // Columns at or above the product width fall outside 2^(2*XLEN).
  assign unused_cols = ^{in_s[COLS-1:2*XLEN], in_c[COLS-1:2*XLEN-1]};

  assign adv2     = !v2_q || out_ready;
  assign in_ready = (!v1_q || adv2) && !flush;
  assign in_fire  = in_valid && in_ready;
  assign move     = v1_q && adv2;

  assign out_valid = v2_q;

  ysyx_040066_add64c u_add_lo (
    .a    (in_s[XLEN-1:0]),
    .b    ({in_c[XLEN-2:0], 1'b0}),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  ysyx_040066_add64c u_add_hi (
    .a    (s1_q.s_hi),
    .b    (s1_q.c_hi),
    .cin  (s1_q.k),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.lo   = lo_sum;
    s1_d.k    = lo_cout;
    s1_d.s_hi = in_s[2*XLEN-1:XLEN];
    s1_d.c_hi = in_c[2*XLEN-2:XLEN-1];
    s1_d.sel  = in_sel;
    s1_d.word = in_word;
    s1_d.tag  = in_tag;
  end

  // Word ops override sel; reserved sel codes fall through to HIGH.
  always_comb begin
    result_d = hi_sum;
    if (s1_q.word)
      result_d = sext_word(s1_q.lo[31:0]);
    else if (s1_q.sel == SEL_LOW)
      result_d = s1_q.lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (flush)        v1_q <= 1'b0;
      else if (in_fire) v1_q <= 1'b1;
      else if (move)    v1_q <= 1'b0;

      // An out transfer in the same cycle as a flush still completes;
      // clearing v2 is correct either way.
      if (flush)          v2_q <= 1'b0;
      else if (move)      v2_q <= 1'b1;
      else if (out_ready) v2_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (in_fire) begin
      s1_q <= s1_d;
    end
  end

  // Only loaded when stage 2 may advance, so a stalled result stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (move) begin
      out_result <= result_d;
      out_tag    <= s1_q.tag;
    end
  end

endmodule

// File: tb/tb_ysyx_040066_mul_final_add.sv
module tb_ysyx_040066_mul_final_add;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [131:0] in_s = '0;
  logic [131:0] in_c = '0;
  logic [1:0]   in_sel = 2'd0;
  logic         in_word = 1'b0;
  logic [4:0]   in_tag = 5'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_result;
  logic [4:0]   out_tag;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] res;
  } exp_t;

  exp_t exp_q[$];

  ysyx_040066_mul_final_add dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_c       (in_c),
    .in_sel     (in_sel),
    .in_word    (in_word),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // Reference: full 128-bit product from the column vectors, then select.
  function automatic logic [63:0] ref_result(input logic [131:0] s, input logic [131:0] c,
                                             input logic [1:0] sel, input logic word);
    logic [127:0] p;
    p = s[127:0] + {c[126:0], 1'b0};
    if (word)           return {{32{p[31]}}, p[31:0]};
    else if (sel == 2'd0) return p[63:0];
    else                return p[127:64];
  endfunction

  task automatic drive(input logic [131:0] s, input logic [131:0] c, input logic [1:0] sel,
                       input logic word, input logic [4:0] tag);
    in_s = s; in_c = c; in_sel = sel; in_word = word; in_tag = tag;
    in_valid = 1'b1;
  endtask

  // One op through an idle pipeline with out_ready=1.
  task automatic run_one(input string name, input logic [131:0] s, input logic [131:0] c,
                         input logic [1:0] sel, input logic word, input logic [4:0] tag,
                         input logic [63:0] exp);
    int n;
    drive(s, c, sel, word, tag);
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    chk1({name, "_accept"}, in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk1({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick;
  endtask

  logic [159:0] r160;
  logic [131:0] rs, rc;
  logic [1:0]   rsel;
  logic         rword;
  logic [4:0]   rtag;
  logic         pend;
  logic         in_fire, out_fire;
  int           sent, got, cyc;
  exp_t         e;

  initial begin
    // Reset
    tick; tick;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 64'h0);
    chk("rst_out_tag", 64'(out_tag), 64'h0);
    rst = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    tick;

    // 1: basic add and latency
    drive(132'h5, 132'h5, 2'd0, 1'b0, 5'd1);
    #1;
    chk1("t1_in_ready", in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    chk1("t1_valid_n0", out_valid, 1'b0);
    tick;
    chk1("t1_valid_n1", out_valid, 1'b1);
    chk("t1_result", out_result, 64'hF);
    chk("t1_tag", 64'(out_tag), 64'd1);
    tick;
    chk1("t1_valid_after", out_valid, 1'b0);

    // 2: carry across halves
    run_one("t2_high", {68'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 132'h1, 2'd1, 1'b0, 5'd2, 64'h2);
    run_one("t2_low",  {68'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 132'h1, 2'd0, 1'b0, 5'd3, 64'h1);

    // 3: word sign extension, sel ignored; reserved sel codes act as HIGH
    run_one("t3_w_sel0", 132'h8000_0000, 132'h0, 2'd0, 1'b1, 5'd4, 64'hFFFF_FFFF_8000_0000);
    run_one("t3_w_sel1", 132'h8000_0000, 132'h0, 2'd1, 1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000);
    run_one("t3_sel2", {68'h1234, 64'h0}, 132'h0, 2'd2, 1'b0, 5'd6, 64'h1234);
    run_one("t3_sel3", {68'h1234, 64'h0}, {68'h0, 64'h8000_0000_0000_0000}, 2'd3, 1'b0, 5'd7,
            64'h1235);
    run_one("t3_ignore_top", {4'hF, 128'h7}, {5'h1F, 127'h0}, 2'd0, 1'b0, 5'd8, 64'h7);

    // 4: stall with three back-to-back inputs
    out_ready = 1'b0;
    drive(132'd10, 132'd0, 2'd0, 1'b0, 5'd4);
    tick;
    drive(132'd20, 132'd0, 2'd0, 1'b0, 5'd5);
    tick;
    drive(132'd30, 132'd0, 2'd0, 1'b0, 5'd6);
    #1;
    chk1("t4_in_ready_full", in_ready, 1'b0);
    chk1("t4_valid", out_valid, 1'b1);
    chk("t4_hold_res0", out_result, 64'd10);
    tick;
    tick;
    chk1("t4_in_ready_full2", in_ready, 1'b0);
    chk("t4_hold_res1", out_result, 64'd10);
    chk("t4_hold_tag1", 64'(out_tag), 64'd4);
    out_ready = 1'b1;
    #1;
    chk1("t4_in_ready_rel", in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    chk1("t4_valid_b", out_valid, 1'b1);
    chk("t4_res_b", out_result, 64'd20);
    chk("t4_tag_b", 64'(out_tag), 64'd5);
    tick;
    chk1("t4_valid_c", out_valid, 1'b1);
    chk("t4_res_c", out_result, 64'd30);
    chk("t4_tag_c", 64'(out_tag), 64'd6);
    tick;
    chk1("t4_empty", out_valid, 1'b0);

    // 5: flush with two in flight
    out_ready = 1'b0;
    drive(132'd40, 132'd0, 2'd0, 1'b0, 5'd7);
    tick;
    drive(132'd50, 132'd0, 2'd0, 1'b0, 5'd8);
    tick;
    drive(132'd60, 132'd0, 2'd0, 1'b0, 5'd9);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk1("t5_in_ready_flush", in_ready, 1'b0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("t5_valid_post", out_valid, 1'b0);
    tick;
    chk1("t5_valid_post2", out_valid, 1'b0);
    tick;
    chk1("t5_valid_post3", out_valid, 1'b0);
    run_one("t5_after", 132'd100, 132'd7, 2'd0, 1'b0, 5'd10, 64'd114);

    // 6a: async reset between edges with two ops in flight
    out_ready = 1'b0;
    drive(132'h77, 132'd0, 2'd0, 1'b0, 5'd3);
    tick;
    drive(132'h88, 132'd0, 2'd0, 1'b0, 5'd4);
    tick;
    in_valid = 1'b0;
    chk1("t6_pre_valid", out_valid, 1'b1);
    chk("t6_pre_result", out_result, 64'h77);
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_result", out_result, 64'h0);
    chk("t6_rst_tag", 64'(out_tag), 64'h0);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk1("t6_rel_in_ready", in_ready, 1'b1);
    tick;
    tick;
    chk1("t6_rel_empty", out_valid, 1'b0);

    // 6b: random ops vs. reference with random out_ready
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    while (got < 10000 && cyc < 80000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!pend && sent < 10000 && $urandom_range(0, 9) < 8) begin
        r160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rs = r160[131:0];
        r160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rc = r160[131:0];
        rsel = 2'($urandom_range(0, 3));
        rword = ($urandom_range(0, 3) == 0);
        rtag = 5'($urandom_range(0, 31));
        drive(rs, rc, rsel, rword, rtag);
        pend = 1'b1;
      end
      #1;
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk1("rnd_unexpected_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_result", out_result, e.res);
          chk("rnd_tag", 64'(out_tag), 64'(e.tag));
        end
        got++;
      end
      if (in_fire) begin
        e.tag = rtag;
        e.res = ref_result(rs, rc, rsel, rword);
        exp_q.push_back(e);
        sent++;
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!pend) in_valid = 1'b0;
      cyc++;
    end
    chk1("rnd_all_ops_returned", (got == 10000), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
